// File: rtl/lcd_hex_printer_if.sv
// Handshake bundle between the binary-to-hex stage (master) and the LCD printer (slave).
// hex_ready is a level held until print_done is seen; print_done is held until hex_ready is seen low.
interface lcd_hex_printer_if;
  logic [127:0] hex_in;
  logic         hex_ready;
  logic         print_done;

  modport master (output hex_in, output hex_ready, input print_done);
  modport slave  (input hex_in, input hex_ready, output print_done);
endinterface

// File: rtl/lcd_hex_printer.sv
// Prints a latched 16-character string on LCD row 1 over the HD44780 4-bit bus,
// including power-up initialisation and all nibble/byte timing.
module lcd_hex_printer #(
  parameter int POWERUP_CYC    = 750000,
  parameter int INIT_LONG_CYC  = 205000,
  parameter int INIT_SHORT_CYC = 5000,
  parameter int SETUP_CYC      = 2,
  parameter int E_PULSE_CYC    = 12,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic             clk,
  input  logic             rst,
  lcd_hex_printer_if.slave hex,
  output logic             init_done,
  output logic [3:0]       lcd_d,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [2:0]       fsm_state
);

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] IDLE     = 3'd2;
  localparam logic [2:0] LATCH    = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [1:0] P_HI   = 2'd0;
  localparam logic [1:0] P_LO   = 2'd1;
  localparam logic [1:0] P_WAIT = 2'd2;

  localparam int SLOT_CYC = SETUP_CYC + E_PULSE_CYC + NIBBLE_GAP_CYC;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, INIT_LONG_CYC),
                                     max2(INIT_SHORT_CYC, CMD_WAIT_CYC)),
                                max2(CLEAR_WAIT_CYC, SLOT_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(INIT_LONG_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(INIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] E_ON       = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] E_OFF      = CNT_W'(SETUP_CYC + E_PULSE_CYC);

  // Init steps 0..3 are single nibbles (only the high half is sent); 4..7 are full command bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] stp);
    case (stp)
      3'd3:    return 8'h20;
      3'd4:    return 8'h28;
      3'd5:    return 8'h06;
      3'd6:    return 8'h0C;
      3'd7:    return 8'h01;
      default: return 8'h30;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] wait_last(input logic [2:0] st, input logic [2:0] stp);
    if (st == SEND) return CMD_LAST;
    case (stp)
      3'd0:    return LONG_LAST;
      3'd1:    return SHORT_LAST;
      3'd7:    return CLEAR_LAST;
      default: return CMD_LAST;
    endcase
  endfunction

  logic [2:0]       state, nxt_state;
  logic [2:0]       step, nxt_step;
  logic [1:0]       part, nxt_part;
  logic             cmd_phase, nxt_cmd_phase;
  logic [3:0]       char_idx, nxt_char_idx;
  logic [CNT_W-1:0] cnt, nxt_cnt, limit;
  logic             done_flag, nxt_done_flag, nxt_init_done;
  logic             latch_en, nib_only;
  logic [127:0]     text;
  logic [3:0]       rev_idx;
  logic [7:0]       nxt_byte;
  logic [4:0]       nxt_bus;
  logic             nxt_in_slot;

  always_comb begin
    nxt_state     = state;
    nxt_step      = step;
    nxt_part      = part;
    nxt_cmd_phase = cmd_phase;
    nxt_char_idx  = char_idx;
    nxt_cnt       = cnt + 1'b1;
    nxt_done_flag = done_flag;
    nxt_init_done = init_done;
    latch_en      = 1'b0;
    nib_only      = (state == INIT) && !step[2];
    limit         = (part == P_WAIT) ? wait_last(state, step) : SLOT_LAST;
    case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          nxt_state = INIT;
          nxt_step  = '0;
          nxt_part  = P_HI;
          nxt_cnt   = '0;
        end
      end
      INIT, SEND: begin
        if (cnt == limit) begin
          nxt_cnt = '0;
          if (part == P_HI) begin
            nxt_part = nib_only ? P_WAIT : P_LO;
          end else if (part == P_LO) begin
            nxt_part = P_WAIT;
          end else begin
            nxt_part = P_HI;
            if (state == INIT) begin
              if (step == 3'd7) begin
                nxt_state     = IDLE;
                nxt_init_done = 1'b1;
              end else begin
                nxt_step = step + 3'd1;
              end
            end else if (cmd_phase) begin
              nxt_cmd_phase = 1'b0;
            end else if (char_idx == 4'd15) begin
              // Completion is tied to char 15's wait, not to the index wrapping.
              nxt_state     = DONE;
              nxt_done_flag = 1'b1;
            end else begin
              nxt_char_idx = char_idx + 4'd1;
            end
          end
        end
      end
      IDLE: begin
        nxt_cnt = '0;
        if (hex.hex_ready && !done_flag) begin
          latch_en  = 1'b1;
          nxt_state = LATCH;
        end
      end
      LATCH: begin
        nxt_state     = SEND;
        nxt_cmd_phase = 1'b1;
        nxt_char_idx  = '0;
        nxt_part      = P_HI;
        nxt_cnt       = '0;
      end
      DONE: begin
        nxt_cnt = '0;
        if (!hex.hex_ready) begin
          nxt_done_flag = 1'b0;
          nxt_state     = IDLE;
        end
      end
      default: begin
        nxt_state = PWR_WAIT;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Bus outputs are registered from the upcoming state so they change exactly at slot boundaries.
  always_comb begin
    rev_idx     = 4'd15 - nxt_char_idx;
    nxt_in_slot = ((nxt_state == INIT) || (nxt_state == SEND)) && (nxt_part != P_WAIT);
    if (nxt_state == INIT)  nxt_byte = init_byte(nxt_step);
    else if (nxt_cmd_phase) nxt_byte = 8'h80;
    else                    nxt_byte = text[{rev_idx, 3'b000} +: 8];
    nxt_bus = {(nxt_state == SEND) && !nxt_cmd_phase,
               (nxt_part == P_HI) ? nxt_byte[7:4] : nxt_byte[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      step      <= '0;
      part      <= P_HI;
      cmd_phase <= 1'b0;
      char_idx  <= '0;
      cnt       <= '0;
      done_flag <= 1'b0;
      init_done <= 1'b0;
      text      <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= 4'h0;
    end else begin
      state     <= nxt_state;
      step      <= nxt_step;
      part      <= nxt_part;
      cmd_phase <= nxt_cmd_phase;
      char_idx  <= nxt_char_idx;
      cnt       <= nxt_cnt;
      done_flag <= nxt_done_flag;
      init_done <= nxt_init_done;
      if (latch_en) text <= hex.hex_in;
      lcd_e <= nxt_in_slot && (nxt_cnt >= E_ON) && (nxt_cnt < E_OFF);
      if (nxt_in_slot && (nxt_cnt == '0)) begin
        lcd_rs <= nxt_bus[4];
        lcd_d  <= nxt_bus[3:0];
      end
    end
  end

  assign hex.print_done = done_flag;
  assign lcd_rw         = 1'b0;
  assign fsm_state      = state;

endmodule

// File: tb/tb_lcd_hex_printer.sv
// Bench for lcd_hex_printer: captures {rs, nibble} on every lcd_e fall and compares it and the
// handshake timing against a string-level model of init and print sequences.
module tb_lcd_hex_printer;
  localparam int P_PWR   = 20;
  localparam int P_LONG  = 10;
  localparam int P_SHORT = 5;
  localparam int P_CMD   = 8;
  localparam int P_CLEAR = 12;
  localparam int P_SETUP = 2;
  localparam int P_E     = 3;
  localparam int P_GAP   = 2;
  localparam int SLOT    = P_SETUP + P_E + P_GAP;
  localparam int BYTE_T  = 2 * SLOT + P_CMD;
  localparam int INIT_T  = P_PWR + 4 * SLOT + P_LONG + P_SHORT + 2 * P_CMD
                         + 4 * (2 * SLOT) + 3 * P_CMD + P_CLEAR;
  localparam int PRINT_T = 1 + 17 * BYTE_T;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;
  logic [2:0] fsm_state;

  lcd_hex_printer_if hex_bus ();

  lcd_hex_printer #(
    .POWERUP_CYC(P_PWR), .INIT_LONG_CYC(P_LONG), .INIT_SHORT_CYC(P_SHORT),
    .SETUP_CYC(P_SETUP), .E_PULSE_CYC(P_E), .NIBBLE_GAP_CYC(P_GAP),
    .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLEAR)
  ) dut (
    .clk(clk), .rst(rst), .hex(hex_bus), .init_done(init_done), .lcd_d(lcd_d),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .fsm_state(fsm_state)
  );

  // Clock and cycle count (cyc = number of rising edges so far).
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // Bus monitor.
  logic [4:0] got_q[$];
  logic [4:0] exp_q[$];
  int         stab_err = 0;
  int         init_rises = 0;
  int         init_rise_cyc = 0;
  int         done_rise_cyc = 0;
  logic       prev_e = 1'b0;
  logic       prev_init = 1'b0;
  logic       prev_done = 1'b0;
  logic [4:0] prev_bus = 5'h0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_e && !lcd_e) got_q.push_back(prev_bus);
      if (prev_e && lcd_e && ({lcd_rs, lcd_d} != prev_bus)) stab_err <= stab_err + 1;
      if (init_done && !prev_init) begin
        init_rises    <= init_rises + 1;
        init_rise_cyc <= cyc;
      end
      if (hex_bus.print_done && !prev_done) done_rise_cyc <= cyc;
    end
    prev_e    <= lcd_e;
    prev_bus  <= {lcd_rs, lcd_d};
    prev_init <= init_done;
    prev_done <= hex_bus.print_done;
  end

  // Driver tasks.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_init(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (init_done === 1'b1) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (hex_bus.print_done === 1'b1) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  function automatic logic [127:0] rand_text();
    logic [127:0] t;
    int v;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 15);
      t = {t[119:0], (v < 10) ? 8'(8'h30 + v) : 8'(8'h37 + v)};
    end
    return t;
  endfunction

  // Reference model: the init sequence and a print, expressed as {rs, nibble} lists.
  task automatic model_init();
    logic [31:0] cmds;
    logic [7:0]  b;
    cmds = 32'h28060C01;
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    for (int i = 0; i < 4; i++) begin
      b = cmds[31 - 8 * i -: 8];
      exp_q.push_back({1'b0, b[7:4]});
      exp_q.push_back({1'b0, b[3:0]});
    end
  endtask

  task automatic model_print(input logic [127:0] s);
    logic [7:0] c;
    exp_q.push_back(5'h08);
    exp_q.push_back(5'h00);
    for (int i = 0; i < 16; i++) begin
      c = s[127 - 8 * i -: 8];
      exp_q.push_back({1'b1, c[7:4]});
      exp_q.push_back({1'b1, c[3:0]});
    end
  endtask

  // Scoreboard lookups: index of first disagreement between captured and expected, or -1.
  function automatic int first_diff(input int base);
    int n;
    n = got_q.size() - base;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= n || got_q[base + i] !== exp_q[i]) return i;
    if (n != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic logic [4:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 5'bx;
  endfunction

  function automatic logic [4:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 5'bx;
  endfunction

  // Scenarios.
  task automatic test_reset();
    rst = 1'b1;
    hex_bus.hex_ready = 1'b0;
    hex_bus.hex_in = '0;
    repeat (3) tick();
    n_total++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_d} !== 7'b0)
      $display("FAIL reset_lcd: got e=%b rs=%b rw=%b d=%h, want all 0", lcd_e, lcd_rs, lcd_rw, lcd_d);
    else n_pass++;
    n_total++;
    if ({init_done, hex_bus.print_done} !== 2'b00)
      $display("FAIL reset_flags: got init_done=%b print_done=%b, want 0 0", init_done, hex_bus.print_done);
    else n_pass++;
  endtask

  task automatic test_init();
    bit ok;
    int k, d, base, s0, r0;
    base = got_q.size();
    exp_q.delete();
    model_init();
    s0 = stab_err;
    r0 = init_rises;
    k = cyc;
    rst = 1'b0;
    wait_init(INIT_T + 50, ok);
    n_total++;
    if (!ok) $display("FAIL init_timeout: init_done never rose, want cycle %0d", k + INIT_T);
    else if (init_rise_cyc != k + INIT_T)
      $display("FAIL init_time: got rise at %0d, want %0d", init_rise_cyc, k + INIT_T);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (init_rises - r0 != 1) $display("FAIL init_once: got %0d rises, want 1", init_rises - r0);
    else n_pass++;
    d = first_diff(base);
    n_total++;
    if (d != -1)
      $display("FAIL init_nibbles: at %0d got %h want %h (count %0d, want %0d)",
               d, got_at(base + d), exp_at(d), got_q.size() - base, exp_q.size());
    else n_pass++;
    n_total++;
    if (stab_err != s0) $display("FAIL init_stable: got %0d bus changes under e, want 0", stab_err - s0);
    else n_pass++;
  endtask

  task automatic test_single_print();
    bit ok;
    int k, d, base;
    logic [127:0] s;
    s = "0123456789ABCDEF";
    base = got_q.size();
    exp_q.delete();
    model_print(s);
    hex_bus.hex_in = s;
    k = cyc;
    hex_bus.hex_ready = 1'b1;
    wait_done(PRINT_T + 50, ok);
    n_total++;
    if (!ok || done_rise_cyc != k + 1 + PRINT_T)
      $display("FAIL print_time: got ok=%0d rise %0d, want %0d", ok, done_rise_cyc, k + 1 + PRINT_T);
    else n_pass++;
    d = first_diff(base);
    n_total++;
    if (d != -1)
      $display("FAIL print_bytes: at %0d got %h want %h", d, got_at(base + d), exp_at(d));
    else n_pass++;
    tick();
    n_total++;
    if (hex_bus.print_done !== 1'b1) $display("FAIL done_hold: got %b, want 1", hex_bus.print_done);
    else n_pass++;
    hex_bus.hex_ready = 1'b0;
    tick();
    n_total++;
    if (hex_bus.print_done !== 1'b0) $display("FAIL done_fall: got %b, want 0", hex_bus.print_done);
    else n_pass++;
  endtask

  task automatic test_hold_ready();
    bit ok;
    int base, lows;
    logic [127:0] s;
    s = rand_text();
    base = got_q.size();
    hex_bus.hex_in = s;
    hex_bus.hex_ready = 1'b1;
    wait_done(PRINT_T + 50, ok);
    lows = ok ? 0 : 1;
    for (int i = 0; i < 3 * BYTE_T; i++) begin
      tick();
      if (hex_bus.print_done !== 1'b1) lows++;
    end
    n_total++;
    if (lows != 0) $display("FAIL hold_done: got %0d cycles low, want 0", lows);
    else n_pass++;
    n_total++;
    if (got_q.size() - base != 34)
      $display("FAIL hold_no_reprint: got %0d nibbles, want 34", got_q.size() - base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k, d, base;
    logic [127:0] s;
    hex_bus.hex_ready = 1'b0;
    tick();
    n_total++;
    if (hex_bus.print_done !== 1'b0) $display("FAIL b2b_fall: got %b, want 0", hex_bus.print_done);
    else n_pass++;
    s = rand_text();
    base = got_q.size();
    exp_q.delete();
    model_print(s);
    hex_bus.hex_in = s;
    k = cyc;
    hex_bus.hex_ready = 1'b1;
    wait_done(PRINT_T + 50, ok);
    n_total++;
    if (!ok || done_rise_cyc != k + 1 + PRINT_T)
      $display("FAIL b2b_time: got ok=%0d rise %0d, want %0d", ok, done_rise_cyc, k + 1 + PRINT_T);
    else n_pass++;
    d = first_diff(base);
    n_total++;
    if (d != -1) $display("FAIL b2b_bytes: at %0d got %h want %h", d, got_at(base + d), exp_at(d));
    else n_pass++;
    hex_bus.hex_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_data_stability();
    bit ok;
    int d, base;
    logic [127:0] s;
    s = rand_text();
    base = got_q.size();
    exp_q.delete();
    model_print(s);
    hex_bus.hex_in = s;
    hex_bus.hex_ready = 1'b1;
    repeat ($urandom_range(40, 300)) tick();
    hex_bus.hex_in = {16{8'h46}};
    wait_done(PRINT_T + 50, ok);
    d = first_diff(base);
    n_total++;
    if (!ok || d != -1)
      $display("FAIL stable_text: ok=%0d at %0d got %h want %h", ok, d, got_at(base + d), exp_at(d));
    else n_pass++;
    hex_bus.hex_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_ready_drop();
    bit ok;
    int d, base;
    logic [127:0] s;
    s = rand_text();
    base = got_q.size();
    exp_q.delete();
    model_print(s);
    hex_bus.hex_in = s;
    hex_bus.hex_ready = 1'b1;
    repeat (2) tick();
    hex_bus.hex_ready = 1'b0;
    hex_bus.hex_in = rand_text();
    wait_done(PRINT_T + 50, ok);
    d = first_diff(base);
    n_total++;
    if (!ok || d != -1)
      $display("FAIL drop_text: ok=%0d at %0d got %h want %h", ok, d, got_at(base + d), exp_at(d));
    else n_pass++;
    tick();
    n_total++;
    if (hex_bus.print_done !== 1'b0) $display("FAIL drop_pulse: got %b one cycle later, want 0", hex_bus.print_done);
    else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_early_request();
    bit ok;
    int k, d, base, i_cyc;
    logic [127:0] s;
    rst = 1'b1;
    repeat (3) tick();
    base = got_q.size();
    exp_q.delete();
    model_init();
    s = rand_text();
    model_print(s);
    hex_bus.hex_in = s;
    hex_bus.hex_ready = 1'b1;
    tick();
    k = cyc;
    rst = 1'b0;
    wait_init(INIT_T + 50, ok);
    i_cyc = init_rise_cyc;
    n_total++;
    if (!ok || i_cyc != k + INIT_T || got_q.size() - base != 12)
      $display("FAIL early_init: ok=%0d rise %0d want %0d, nibbles %0d want 12",
               ok, i_cyc, k + INIT_T, got_q.size() - base);
    else n_pass++;
    wait_done(PRINT_T + 50, ok);
    n_total++;
    if (!ok || done_rise_cyc != i_cyc + 1 + PRINT_T)
      $display("FAIL early_time: got ok=%0d rise %0d, want %0d", ok, done_rise_cyc, i_cyc + 1 + PRINT_T);
    else n_pass++;
    d = first_diff(base);
    n_total++;
    if (d != -1) $display("FAIL early_bytes: at %0d got %h want %h", d, got_at(base + d), exp_at(d));
    else n_pass++;
    hex_bus.hex_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_print();
    bit found;
    int base, data_n;
    base = got_q.size();
    hex_bus.hex_in = rand_text();
    hex_bus.hex_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < PRINT_T + 50 && !found; i++) begin
      data_n = 0;
      for (int j = base; j < got_q.size(); j++) if (got_q[j][4]) data_n++;
      if (data_n == 14 && lcd_e === 1'b1) found = 1'b1;
      else tick();
    end
    n_total++;
    if (!found) $display("FAIL midreset_reach: char 7 strobe not seen, want e=1 after 14 data nibbles");
    else n_pass++;
    rst = 1'b1;
    hex_bus.hex_ready = 1'b0;
    tick();
    n_total++;
    if ({lcd_e, lcd_d, hex_bus.print_done, init_done} !== 7'b0)
      $display("FAIL midreset_out: got e=%b d=%h done=%b init=%b, want all 0",
               lcd_e, lcd_d, hex_bus.print_done, init_done);
    else n_pass++;
  endtask

  initial begin
    hex_bus.hex_in = '0;
    hex_bus.hex_ready = 1'b0;
    test_reset();
    test_init();
    test_single_print();
    test_hold_ready();
    test_back_to_back();
    test_data_stability();
    test_ready_drop();
    test_early_request();
    test_reset_mid_print();
    test_init();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
